// File: rtl/serial_compare_arbiter_if.sv
// serial_compare_arbiter_if: request/grant, comparator and result bundle for serial_compare_arbiter.
// Ports (as signals):
//   req0/req1, op_a0/op_b0/op_a1/op_b1  requester side, into the arbiter
//   gnt[1:0]                            one-hot acceptance pulse
//   cmp_a/cmp_b, cmp_gt/cmp_eq/cmp_lt   external 2-bit comparator slice and its flags
//   busy, res_valid, res_id, res_*      status and result
// Modport slave is the arbiter; modport master is everything around it.
interface serial_compare_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic [WIDTH-1:0] op_a0;
    logic [WIDTH-1:0] op_b0;
    logic             req1;
    logic [WIDTH-1:0] op_a1;
    logic [WIDTH-1:0] op_b1;
    logic [1:0]       gnt;
    logic [1:0]       cmp_a;
    logic [1:0]       cmp_b;
    logic             cmp_gt;
    logic             cmp_eq;
    logic             cmp_lt;
    logic             busy;
    logic             res_valid;
    logic             res_id;
    logic             res_gt;
    logic             res_eq;
    logic             res_lt;
    logic             res_err;

    modport slave (
        input  req0, op_a0, op_b0, req1, op_a1, op_b1, cmp_gt, cmp_eq, cmp_lt,
        output gnt, cmp_a, cmp_b, busy, res_valid, res_id, res_gt, res_eq, res_lt, res_err
    );

    modport master (
        output req0, op_a0, op_b0, req1, op_a1, op_b1, cmp_gt, cmp_eq, cmp_lt,
        input  gnt, cmp_a, cmp_b, busy, res_valid, res_id, res_gt, res_eq, res_lt, res_err
    );
endinterface

// File: rtl/serial_compare_arbiter.sv
// serial_compare_arbiter: round-robin arbiter that compares two WIDTH-bit operands
// two bits at a time (MSB slice first) through a shared external 2-bit comparator.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_compare_arbiter_if.slave (requests, comparator slice, results)
module serial_compare_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    serial_compare_arbiter_if.slave      bus
);
    localparam int DIGITS = WIDTH / 2;
    localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

    state_t           state_q;
    logic [1:0]       gnt_q;
    logic [1:0]       cmp_a_q;
    logic [1:0]       cmp_b_q;
    logic [WIDTH-1:0] sh_a_q;
    logic [WIDTH-1:0] sh_b_q;
    logic [IW-1:0]    idx_q;
    logic             owner_q;
    logic             last_q;
    logic             busy_q;
    logic             res_valid_q;
    logic             res_id_q;
    logic             res_gt_q;
    logic             res_eq_q;
    logic             res_lt_q;
    logic             res_err_q;

    logic             sel_d;
    logic             one_hot_d;
    logic [WIDTH-1:0] op_a_d;
    logic [WIDTH-1:0] op_b_d;

    // On a tie the requester not granted last wins; a lone request always wins.
    assign sel_d     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    assign op_a_d    = sel_d ? bus.op_a1 : bus.op_a0;
    assign op_b_d    = sel_d ? bus.op_b1 : bus.op_b0;
    assign one_hot_d = $onehot({bus.cmp_gt, bus.cmp_eq, bus.cmp_lt});

    // Operands are kept as left-shifting registers so the next slice is always
    // the top two bits; idx_q only counts how many slices remain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            cmp_a_q     <= '0;
            cmp_b_q     <= '0;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            idx_q       <= '0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_gt_q    <= 1'b0;
            res_eq_q    <= 1'b0;
            res_lt_q    <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            gnt_q       <= '0;
            res_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        state_q <= COMPARE;
                        busy_q  <= 1'b1;
                        gnt_q   <= sel_d ? 2'b10 : 2'b01;
                        owner_q <= sel_d;
                        idx_q   <= IW'(DIGITS - 1);
                        cmp_a_q <= op_a_d[WIDTH-1 -: 2];
                        cmp_b_q <= op_b_d[WIDTH-1 -: 2];
                        sh_a_q  <= op_a_d << 2;
                        sh_b_q  <= op_b_d << 2;
                    end
                end
                COMPARE: begin
                    if (one_hot_d && bus.cmp_eq && idx_q != '0) begin
                        idx_q   <= idx_q - IW'(1);
                        cmp_a_q <= sh_a_q[WIDTH-1 -: 2];
                        cmp_b_q <= sh_b_q[WIDTH-1 -: 2];
                        sh_a_q  <= sh_a_q << 2;
                        sh_b_q  <= sh_b_q << 2;
                    end else begin
                        state_q     <= DONE;
                        cmp_a_q     <= '0;
                        cmp_b_q     <= '0;
                        res_valid_q <= 1'b1;
                        res_id_q    <= owner_q;
                        res_gt_q    <= one_hot_d && bus.cmp_gt;
                        res_eq_q    <= one_hot_d && bus.cmp_eq;
                        res_lt_q    <= one_hot_d && bus.cmp_lt;
                        res_err_q   <= !one_hot_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    last_q  <= res_id_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.cmp_a     = cmp_a_q;
    assign bus.cmp_b     = cmp_b_q;
    assign bus.busy      = busy_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_gt    = res_gt_q;
    assign bus.res_eq    = res_eq_q;
    assign bus.res_lt    = res_lt_q;
    assign bus.res_err   = res_err_q;
endmodule
